// File: rtl/multi_repeater_pkg.sv
// Shared types and constants for the multi-target repeater.
// Package name is rpt_pkg; imported by multi_repeater.
package rpt_pkg;

  // Run controller states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EMIT   = 2'd1,
    WAIT_T = 2'd2,
    WAIT_M = 2'd3
  } rpt_state_e;

  // Pacing modes carried on the MODE input
  localparam logic MODE_SELF = 1'b0;
  localparam logic MODE_EXT  = 1'b1;

endpackage

// File: rtl/multi_repeater_rise_detect.sv
// Registered single-bit rising-edge detector.
// RESET_VAL sets the remembered level after reset, so a line that is
// already high when reset releases does not look like a fresh edge.
module rise_detect #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic sig_i,
  output logic rise_o
);

  logic prev_q;

  // Remember the previous sample of the input line
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      prev_q <= RESET_VAL;
    end else begin
      prev_q <= sig_i;
    end
  end

  assign rise_o = sig_i & ~prev_q;

endmodule

// File: rtl/multi_repeater.sv
// Multi-target repeater: issues a programmable number of one-cycle kicks
// to up to NCH engines, broadcast or one channel at a time in ascending
// index order, with optional external pacing and a post-margin gap.
// Optional feature: define RPT_WATCHDOG_EN to add a WAIT_T watchdog that
// ends a stuck run after WDT_CYCLES cycles and raises ERR.
module multi_repeater
  import rpt_pkg::*;
#(
  parameter int NCH        = 4,
  parameter int CNT_W      = 16,
  parameter int WDT_CYCLES = 65535
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             KICK,
  input  logic             ABORT,
  input  logic             MODE,
  input  logic             SEQ,
  input  logic [NCH-1:0]   CH_MASK,
  input  logic [CNT_W-1:0] REPETITION,
  input  logic [CNT_W-1:0] POST_MARGIN,
  input  logic             EXT_TRIG,
  output logic [NCH-1:0]   TARGET_KICK,
  input  logic [NCH-1:0]   TARGET_BUSY,
  output logic             BUSY,
  output logic             DONE,
  output logic             ABORTED,
  output logic             ERR,
  output logic [CNT_W-1:0] COUNT
);

  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

  // Lowest set index of mask at or above start; MSB of the result is the found flag
  function automatic logic [IDX_W:0] find_from(input logic [NCH-1:0] mask, input int start);
    logic [IDX_W:0] res;
    res = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask[i] && (i >= start)) begin
        res = {1'b1, IDX_W'(i)};
      end
    end
    return res;
  endfunction

  rpt_state_e       state_q, state_d;
  logic             mode_q, mode_d;
  logic             seq_q, seq_d;
  logic [NCH-1:0]   mask_q, mask_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic [CNT_W-1:0] margin_q, margin_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] mcnt_q, mcnt_d;
  logic [IDX_W-1:0] chan_q, chan_d;
  logic [IDX_W-1:0] first_ch_q, first_ch_d;
  logic             rep_first_q, rep_first_d;
  logic [NCH-1:0]   kick_q, kick_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;
`ifdef RPT_WATCHDOG_EN
  logic             err_q, err_d;
  logic [31:0]      wdt_q, wdt_d;
`else
  logic             wdt_unused;
  assign wdt_unused = (WDT_CYCLES != 0);
`endif

  logic             kick_rise;
  logic             trig_rise;
  logic [NCH-1:0]   kicked_mask;
  logic             targets_idle;
  logic             trig_ok;
  logic             fire;
  logic [IDX_W:0]   start_hit;
  logic [IDX_W:0]   next_hit;
  logic             end_chk;

  rise_detect #(.RESET_VAL(1'b1)) u_kick_rise (
    .clk_i  (CLK),
    .reset_i(RESET),
    .sig_i  (KICK),
    .rise_o (kick_rise)
  );

  rise_detect #(.RESET_VAL(1'b1)) u_trig_rise (
    .clk_i  (CLK),
    .reset_i(RESET),
    .sig_i  (EXT_TRIG),
    .rise_o (trig_rise)
  );

  // Channels hit by the next kick: whole mask in broadcast, only the current channel in sequential
  always_comb begin
    kicked_mask = mask_q;
    if (seq_q) begin
      for (int i = 0; i < NCH; i++) begin
        kicked_mask[i] = (chan_q == IDX_W'(i));
      end
    end
  end

  assign targets_idle = ((TARGET_BUSY & kicked_mask) == '0);
  assign trig_ok      = (mode_q != MODE_EXT) || !rep_first_q || trig_rise;
  assign fire         = targets_idle && trig_ok;
  assign start_hit    = find_from(CH_MASK, 0);
  assign next_hit     = find_from(mask_q, int'(chan_q) + 1);

  // State register and all run bookkeeping, synchronous reset
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      mode_q      <= MODE_SELF;
      seq_q       <= 1'b0;
      mask_q      <= '0;
      rep_q       <= '0;
      margin_q    <= '0;
      count_q     <= '0;
      mcnt_q      <= '0;
      chan_q      <= '0;
      first_ch_q  <= '0;
      rep_first_q <= 1'b0;
      kick_q      <= '0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
`ifdef RPT_WATCHDOG_EN
      err_q       <= 1'b0;
      wdt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      seq_q       <= seq_d;
      mask_q      <= mask_d;
      rep_q       <= rep_d;
      margin_q    <= margin_d;
      count_q     <= count_d;
      mcnt_q      <= mcnt_d;
      chan_q      <= chan_d;
      first_ch_q  <= first_ch_d;
      rep_first_q <= rep_first_d;
      kick_q      <= kick_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
`ifdef RPT_WATCHDOG_EN
      err_q       <= err_d;
      wdt_q       <= wdt_d;
`endif
    end
  end

  // Next-state logic: start, kick emission, completion tracking, end-check, abort override
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    seq_d       = seq_q;
    mask_d      = mask_q;
    rep_d       = rep_q;
    margin_d    = margin_q;
    count_d     = count_q;
    mcnt_d      = mcnt_q;
    chan_d      = chan_q;
    first_ch_d  = first_ch_q;
    rep_first_d = rep_first_q;
    kick_d      = '0;
    done_d      = 1'b0;
    aborted_d   = aborted_q;
    end_chk     = 1'b0;
`ifdef RPT_WATCHDOG_EN
    err_d       = err_q;
    wdt_d       = wdt_q;
`endif

    case (state_q)
      IDLE: begin
        if (kick_rise && !ABORT) begin
          mode_d      = MODE;
          seq_d       = SEQ;
          mask_d      = CH_MASK;
          rep_d       = REPETITION;
          margin_d    = POST_MARGIN;
          count_d     = '0;
          aborted_d   = 1'b0;
`ifdef RPT_WATCHDOG_EN
          err_d       = 1'b0;
`endif
          if (!start_hit[IDX_W]) begin
            done_d = 1'b1;
          end else begin
            state_d     = EMIT;
            chan_d      = start_hit[IDX_W-1:0];
            first_ch_d  = start_hit[IDX_W-1:0];
            rep_first_d = 1'b1;
          end
        end
      end

      EMIT: begin
        if (fire) begin
          kick_d      = kicked_mask;
          rep_first_d = 1'b0;
          if (rep_first_q) begin
            count_d = count_q + 1'b1;
          end
          state_d = WAIT_T;
`ifdef RPT_WATCHDOG_EN
          wdt_d   = '0;
`endif
        end
      end

      WAIT_T: begin
        if ((kick_q == '0) && targets_idle) begin
          if (seq_q && next_hit[IDX_W]) begin
            chan_d  = next_hit[IDX_W-1:0];
            state_d = EMIT;
          end else begin
            chan_d = first_ch_q;
            if (margin_q != '0) begin
              mcnt_d  = margin_q - 1'b1;
              state_d = WAIT_M;
            end else begin
              end_chk = 1'b1;
            end
          end
        end
`ifdef RPT_WATCHDOG_EN
        else if (wdt_q == 32'(WDT_CYCLES - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          wdt_d = wdt_q + 32'd1;
        end
`endif
      end

      WAIT_M: begin
        if (mcnt_q == '0) begin
          end_chk = 1'b1;
        end else begin
          mcnt_d = mcnt_q - 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (end_chk) begin
      if ((rep_q != '0) && (count_q == rep_q)) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else begin
        state_d     = EMIT;
        rep_first_d = 1'b1;
      end
    end

    if (ABORT && (state_q != IDLE)) begin
      state_d   = IDLE;
      kick_d    = '0;
      done_d    = 1'b1;
      aborted_d = 1'b1;
    end
  end

  // Outputs come straight from registers or the state
  always_comb begin
    TARGET_KICK = kick_q;
    BUSY        = (state_q != IDLE);
    DONE        = done_q;
    ABORTED     = aborted_q;
    COUNT       = count_q;
`ifdef RPT_WATCHDOG_EN
    ERR         = err_q;
`else
    ERR         = 1'b0;
`endif
  end

endmodule
